// File: rtl/mdu_issue_ctrl.sv
// E-stage issue and hazard controller for the multiply/divide unit: start pulse,
// shadow latency countdown, D-stage stall request and busy cross-check.
module mdu_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       E_MDUOp,
    input  logic             E_valid,
    input  logic             E_advance,
    input  logic             D_is_mdu,
    input  logic             IntReq,
    input  logic             mdu_busy,
    output logic             start,
    output logic             stall_req,
    output logic             pending,
    output logic [CNT_W-1:0] remaining,
    output logic             sync_err
);

    // Arithmetic encodings from the shared MDU constants; the move/read ops never start
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining_next;
    logic             issued;
    logic             is_div;
    logic             is_md;

    assign is_div = (E_MDUOp == MDU_DIV) || (E_MDUOp == MDU_DIVU);
    assign is_md  = E_valid && ((E_MDUOp == MDU_MULT) || (E_MDUOp == MDU_MULTU) || is_div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // Countdown mirrors the unit's busy window: RUN covers exactly the busy cycles
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = RUN;
                    remaining_next = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end
            end
            RUN: begin
                if (remaining <= CNT_W'(1)) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                end else begin
                    remaining_next = remaining - CNT_W'(1);
                end
            end
            default: begin
                state_next     = IDLE;
                remaining_next = '0;
            end
        endcase
    end

    always_comb begin
        start     = is_md && (state == IDLE) && !IntReq && !issued;
        pending   = start || (state == RUN);
        stall_req = D_is_mdu && pending;
    end

    // An advancing E stage retires the instruction, so clear takes priority over set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued <= 1'b0;
        end else if (E_advance) begin
            issued <= 1'b0;
        end else if (start) begin
            issued <= 1'b1;
        end
    end

    // Busy rises one cycle after start, so the issue cycle compares IDLE against low busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_err <= 1'b0;
        end else if ((state == RUN) != mdu_busy) begin
            sync_err <= 1'b1;
        end
    end

endmodule
